// File: rtl/core_alu_arbiter.sv
// core_alu_arbiter: round-robin sharing of one core_alu between the
// execute stage (port 0) and the address/branch-compare unit (port 1).

module core_alu #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) (
    input  logic              i_eval_en,
    input  logic [FUNC_W-1:0] i_func,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output logic [DATA_W-1:0] o_result
);

    localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_SLL  = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_SLT  = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] F_SLTU = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_XOR  = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_SRL  = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_SRA  = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(9);

    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_res;

    assign w_shamt  = i_op2[4:0];
    assign o_result = w_res;

    // Function decode; output is forced to zero when not enabled
    always_comb begin
        w_res = '0;
        if (i_eval_en) begin
            unique case (i_func)
                F_ADD:   w_res = i_op1 + i_op2;
                F_SUB:   w_res = i_op1 - i_op2;
                F_SLL:   w_res = i_op1 << w_shamt;
                F_SLT:   w_res = {{(DATA_W-1){1'b0}},
                                  ($signed(i_op1) < $signed(i_op2))};
                F_SLTU:  w_res = {{(DATA_W-1){1'b0}}, (i_op1 < i_op2)};
                F_XOR:   w_res = i_op1 ^ i_op2;
                F_SRL:   w_res = i_op1 >> w_shamt;
                F_SRA:   w_res = $unsigned($signed(i_op1) >>> w_shamt);
                F_OR:    w_res = i_op1 | i_op2;
                F_AND:   w_res = i_op1 & i_op2;
                default: w_res = '0;
            endcase
        end
    end

endmodule

module core_alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_in,
    input  logic              req0_valid_in,
    output logic              req0_ready_out,
    input  logic [DATA_W-1:0] req0_op1_in,
    input  logic [DATA_W-1:0] req0_op2_in,
    input  logic [FUNC_W-1:0] req0_func_in,
    input  logic              req1_valid_in,
    output logic              req1_ready_out,
    input  logic [DATA_W-1:0] req1_op1_in,
    input  logic [DATA_W-1:0] req1_op2_in,
    input  logic [FUNC_W-1:0] req1_func_in,
    output logic              rsp0_valid_out,
    input  logic              rsp0_ready_in,
    output logic              rsp1_valid_out,
    input  logic              rsp1_ready_in,
    output logic [DATA_W-1:0] rsp_data_out,
    output logic              busy_out
);

    localparam logic ALU_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic              r_owner;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [FUNC_W-1:0] r_func;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;

    logic              w_gnt_vld;
    logic              w_gnt_id;
    logic              w_accept;
    logic              w_rsp_hs;
    logic              w_eval_en;
    logic [DATA_W-1:0] w_alu_res;

    // Round-robin pick: on contention the port that did not win last goes
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (req0_valid_in && req1_valid_in) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = ~r_last_grant;
        end else if (req0_valid_in) begin
            w_gnt_vld = 1'b1;
        end else if (req1_valid_in) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = 1'b1;
        end
    end

    assign w_accept  = !rst && (r_state == IDLE) && w_gnt_vld && !flush_in;
    assign w_rsp_hs  = (r_state == RESP) &&
                       (r_owner ? rsp1_ready_in : rsp0_ready_in);
    assign w_eval_en = (r_state == EXEC) ? ALU_ENABLE : ~ALU_ENABLE;

    core_alu #(
        .DATA_W (DATA_W),
        .FUNC_W (FUNC_W)
    ) u_alu (
        .i_eval_en (w_eval_en),
        .i_func    (r_func),
        .i_op1     (r_op1),
        .i_op2     (r_op2),
        .o_result  (w_alu_res)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: flush wins over accept and response handshake
    always_comb begin
        w_state_nxt = r_state;
        if (flush_in) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (w_accept) w_state_nxt = EXEC;
                EXEC:    w_state_nxt = RESP;
                RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Operand capture, result register and response valids
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_func       <= '0;
            r_rsp_data   <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else if (flush_in) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                r_op1        <= w_gnt_id ? req1_op1_in  : req0_op1_in;
                r_op2        <= w_gnt_id ? req1_op2_in  : req0_op2_in;
                r_func       <= w_gnt_id ? req1_func_in : req0_func_in;
            end
            if (r_state == EXEC) begin
                r_rsp_data   <= w_alu_res;
                r_rsp0_valid <= !r_owner;
                r_rsp1_valid <= r_owner;
            end
            if (w_rsp_hs) begin
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign req0_ready_out = w_accept && !w_gnt_id;
    assign req1_ready_out = w_accept && w_gnt_id;
    assign rsp0_valid_out = r_rsp0_valid;
    assign rsp1_valid_out = r_rsp1_valid;
    assign rsp_data_out   = r_rsp_data;
    assign busy_out       = (r_state != IDLE);

endmodule

// File: tb/tb_core_alu_arbiter.sv
// tb_core_alu_arbiter: directed scenarios plus random traffic checked
// against a transaction-level reference of the arbiter and ALU.

module tb_core_alu_arbiter;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_SLL  = 4'd2;
    localparam logic [3:0] F_SLTU = 4'd4;
    localparam logic [3:0] F_SRA  = 4'd7;
    localparam logic [3:0] F_XOR  = 4'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_in;
    logic        req0_valid_in, req1_valid_in;
    logic        req0_ready_out, req1_ready_out;
    logic [31:0] req0_op1_in, req0_op2_in, req1_op1_in, req1_op2_in;
    logic [3:0]  req0_func_in, req1_func_in;
    logic        rsp0_valid_out, rsp1_valid_out;
    logic        rsp0_ready_in, rsp1_ready_in;
    logic [31:0] rsp_data_out;
    logic        busy_out;

    int n_vec = 0;
    int n_err = 0;

    // reference state: one transaction in flight at most
    bit          m_busy;
    int          m_age;
    bit          m_owner;
    bit          m_last;
    logic [31:0] m_res;
    logic [31:0] m_data;
    bit          m_acc0, m_acc1;

    // outputs observed at the last tick
    logic        s_rdy0, s_rdy1, s_v0, s_v1, s_busy;
    logic [31:0] s_data;

    core_alu_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush_in       (flush_in),
        .req0_valid_in  (req0_valid_in),
        .req0_ready_out (req0_ready_out),
        .req0_op1_in    (req0_op1_in),
        .req0_op2_in    (req0_op2_in),
        .req0_func_in   (req0_func_in),
        .req1_valid_in  (req1_valid_in),
        .req1_ready_out (req1_ready_out),
        .req1_op1_in    (req1_op1_in),
        .req1_op2_in    (req1_op2_in),
        .req1_func_in   (req1_func_in),
        .rsp0_valid_out (rsp0_valid_out),
        .rsp0_ready_in  (rsp0_ready_in),
        .rsp1_valid_out (rsp1_valid_out),
        .rsp1_ready_in  (rsp1_ready_in),
        .rsp_data_out   (rsp_data_out),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(logic [3:0] f,
                                            logic [31:0] a,
                                            logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: return (a >> sh) |
                         (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_age  = 0;
        m_owner = 0;
        m_last = 1;
        m_res  = '0;
        m_data = '0;
        m_acc0 = 0;
        m_acc1 = 0;
    endtask

    // one clock: check outputs at negedge, advance reference at posedge
    task automatic tick();
        bit gv, gi, acc;
        @(negedge clk);
        gv = 0;
        gi = 0;
        if (req0_valid_in && req1_valid_in) begin
            gv = 1;
            gi = !m_last;
        end else if (req0_valid_in) begin
            gv = 1;
        end else if (req1_valid_in) begin
            gv = 1;
            gi = 1;
        end
        acc = !m_busy && gv && !flush_in;
        chk("req0_ready", req0_ready_out, acc && !gi);
        chk("req1_ready", req1_ready_out, acc && gi);
        chk("rsp0_valid", rsp0_valid_out, m_busy && m_age > 0 && !m_owner);
        chk("rsp1_valid", rsp1_valid_out, m_busy && m_age > 0 && m_owner);
        chk("rsp_data", rsp_data_out, m_data);
        chk("busy", busy_out, m_busy);
        s_rdy0 = req0_ready_out;
        s_rdy1 = req1_ready_out;
        s_v0   = rsp0_valid_out;
        s_v1   = rsp1_valid_out;
        s_data = rsp_data_out;
        s_busy = busy_out;
        @(posedge clk);
        m_acc0 = 0;
        m_acc1 = 0;
        if (flush_in) begin
            m_busy = 0;
        end else if (acc) begin
            m_busy  = 1;
            m_age   = 0;
            m_owner = gi;
            m_last  = gi;
            m_res   = gi ? alu_ref(req1_func_in, req1_op1_in, req1_op2_in)
                         : alu_ref(req0_func_in, req0_op1_in, req0_op2_in);
            if (gi) m_acc1 = 1;
            else    m_acc0 = 1;
        end else if (m_busy && m_age == 0) begin
            m_data = m_res;
            m_age  = 1;
        end else if (m_busy && (m_owner ? rsp1_ready_in : rsp0_ready_in)) begin
            m_busy = 0;
        end
        #1;
    endtask

    task automatic set_req(bit p, bit v, logic [31:0] a, logic [31:0] b,
                           logic [3:0] f);
        if (p) begin
            req1_valid_in = v;
            req1_op1_in   = a;
            req1_op2_in   = b;
            req1_func_in  = f;
        end else begin
            req0_valid_in = v;
            req0_op1_in   = a;
            req0_op2_in   = b;
            req0_func_in  = f;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        flush_in = 0;
        req0_valid_in = 0;
        req1_valid_in = 1;
        #2;
        chk("rst_rdy1", req1_ready_out, 0);
        chk("rst_v0", rsp0_valid_out, 0);
        chk("rst_v1", rsp1_valid_out, 0);
        chk("rst_data", rsp_data_out, 0);
        chk("rst_busy", busy_out, 0);
        req1_valid_in = 0;
        model_reset();
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic drain();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        flush_in = 0;
        rsp0_ready_in = 1;
        rsp1_ready_in = 1;
        repeat (4) tick();
        chk("drain_busy", s_busy, 0);
    endtask

    task automatic run_op(bit p, logic [31:0] a, logic [31:0] b,
                          logic [3:0] f, logic [31:0] exp, string tag);
        set_req(p, 1, a, b, f);
        rsp0_ready_in = 1;
        rsp1_ready_in = 1;
        tick();
        chk({tag, "_rdy"}, p ? s_rdy1 : s_rdy0, 1);
        set_req(p, 0, 0, 0, 0);
        tick();
        tick();
        chk({tag, "_data"}, s_data, exp);
        chk({tag, "_vld"}, p ? s_v1 : s_v0, 1);
        chk({tag, "_oth"}, p ? s_v0 : s_v1, 0);
        tick();
        chk({tag, "_idle"}, s_busy, 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit g;
        rsp0_ready_in = 0;
        rsp1_ready_in = 0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        do_reset();

        run_op(0, 32'hFFFF_FFFF, 32'h2, F_ADD, 32'h1, "add");

        do_reset();
        rsp0_ready_in = 1;
        rsp1_ready_in = 1;
        set_req(0, 1, 32'd5, 32'd7, F_SUB);
        set_req(1, 1, 32'd3, 32'hFFFF_FFFF, F_SLTU);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_order", {31'b0, s_rdy1}, k % 2);
            chk("rr_one", {31'b0, s_rdy0 ^ s_rdy1}, 1);
            g = s_rdy1;
            tick();
            tick();
            chk("rr_data", s_data, g ? 32'h1 : 32'hFFFF_FFFE);
        end
        drain();

        set_req(1, 1, 32'h8000_0000, 32'd4, F_SRA);
        rsp1_ready_in = 0;
        tick();
        set_req(1, 0, 0, 0, 0);
        set_req(0, 1, 32'd1, 32'd1, F_ADD);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_data", s_data, 32'hF800_0000);
            chk("bp_v1", s_v1, 1);
            chk("bp_rdy0", s_rdy0, 0);
        end
        rsp1_ready_in = 1;
        tick();
        drain();

        set_req(0, 1, 32'd10, 32'd20, F_ADD);
        tick();
        set_req(0, 1, 32'd7, 32'd8, F_XOR);
        flush_in = 1;
        tick();
        flush_in = 0;
        tick();
        chk("flx_busy", s_busy, 0);
        chk("flx_v0", s_v0, 0);
        chk("flx_gnt", s_rdy0, 1);
        drain();

        rsp0_ready_in = 0;
        set_req(0, 1, 32'd1, 32'd2, F_ADD);
        tick();
        set_req(0, 1, 32'd9, 32'd9, F_SUB);
        tick();
        tick();
        chk("flr_v0", s_v0, 1);
        flush_in = 1;
        tick();
        flush_in = 0;
        tick();
        chk("flr_busy", s_busy, 0);
        chk("flr_v0b", s_v0, 0);
        chk("flr_gnt", s_rdy0, 1);
        drain();

        rsp0_ready_in = 0;
        set_req(0, 1, 32'd4, 32'd4, F_ADD);
        tick();
        set_req(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("ar_pre", s_v0, 1);
        #2 rst = 1;
        set_req(0, 1, 32'd1, 32'd2, F_ADD);
        set_req(1, 1, 32'd3, 32'd4, F_ADD);
        #1;
        chk("ar_busy", busy_out, 0);
        chk("ar_v0", rsp0_valid_out, 0);
        chk("ar_data", rsp_data_out, 0);
        chk("ar_rdy0", req0_ready_out, 0);
        chk("ar_rdy1", req1_ready_out, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        rsp0_ready_in = 1;
        tick();
        chk("ar_rr", s_rdy0, 1);
        drain();

        run_op(0, 32'h1234_5678, 32'h1234_5678, 4'hF, 32'h0, "unk");
        run_op(1, 32'h3, 32'h21, F_SLL, 32'h6, "sll");

        for (int c = 0; c < 3000; c++) begin
            if (!req0_valid_in || m_acc0)
                set_req(0, $urandom_range(0, 9) < 6, rnd_val(), rnd_val(),
                        4'($urandom_range(0, 15)));
            else if ($urandom_range(0, 19) == 0)
                req0_valid_in = 0;
            if (!req1_valid_in || m_acc1)
                set_req(1, $urandom_range(0, 9) < 6, rnd_val(), rnd_val(),
                        4'($urandom_range(0, 15)));
            else if ($urandom_range(0, 19) == 0)
                req1_valid_in = 0;
            rsp0_ready_in = $urandom_range(0, 9) < 7;
            rsp1_ready_in = $urandom_range(0, 9) < 7;
            flush_in = $urandom_range(0, 24) == 0;
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
